fp_compare_unit: RTL and testbench
==================================

# fp_compare_unit

Pipelined floating-point compare/select unit for the FPU. It performs FEQ, FLT, FLE, FMIN and FMAX on IEEE-754 single or double operands, with IEEE invalid-flag generation and per-transaction tag passthrough. It is the parametrised successor to the combinational less-than block and sits between FPU operand issue and writeback behind a valid/ready handshake.

## Interface
- BUS_WIDTH, 64: operand/result width; only 32 or 64 legal (mantissa 23/52, exponent 8/11).
- TAG_WIDTH, 5: width of the opaque tag (e.g. destination register) carried alongside each operation.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts an operation this cycle.
- in_op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; others reserved.
- in_a  input  BUS_WIDTH  operand A.
- in_b  input  BUS_WIDTH  operand B.
- in_tag  input  TAG_WIDTH  tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  BUS_WIDTH  result: compares give zero-extended 0/1; FMIN/FMAX give the selected operand or canonical NaN.
- out_nv  output  1  invalid-operation flag.
- out_tag  output  TAG_WIDTH  tag of the result.

## Operation
- Transfer on the input side when in_valid&in_ready; on the output side when out_valid&out_ready.
- Field split: sign = MSB, exponent = next 8/11 bits, mantissa = low 23/52 bits.
- NaN means exponent all-ones with nonzero mantissa. sNaN means NaN with mantissa MSB = 0.
- Canonical NaN: 32'h7FC00000 or 64'h7FF8000000000000.
- Ordering: total-order magnitude compare via sign plus {exp,mant}. For compares, +0 == -0.
- FEQ: 1 iff neither operand is NaN and the operands are equal. nv=1 only if either operand is sNaN.
- FLT/FLE: 0 if either operand is NaN, with nv=1 on any NaN (qNaN included).
- FMIN/FMAX:
  - both NaN -> canonical NaN.
  - one NaN -> the other operand.
  - otherwise the smaller/larger operand, with -0 treated as less than +0.
  - nv=1 iff either operand is sNaN.
- Reserved in_op: accepted; out_data=0, out_nv=1, tag passed through.
- Pipeline: stage S1 registers classification (isnan, issnan, iszero per operand), the raw operands, the lt/eq bits, op and tag. Stage S2 registers the final out_data, out_nv and out_tag.
- State: s1_valid, s2_valid plus the data registers listed above.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, with no stall.
- Throughput: 1 operation/cycle.
- s2_adv = !s2_valid | out_ready.
- s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. in_ready is combinational from out_ready and the valids; there is no combinational path from in_valid.
- Stall: while out_valid & !out_ready, out_data, out_nv and out_tag hold stable. S1 holds if it is full.
- Bubble: with S2 empty and S1 full, S1 moves to S2 regardless of out_ready.
- Simultaneous accept and drain in the same cycle: both complete, full throughput, no lost or duplicated operation.
- Reset: s1_valid=s2_valid=0, out_valid=0, out_data=0, out_nv=0, out_tag=0, in_ready=1 on the cycle after reset.
  - Reset mid-operation drops all in-flight operations; nothing is emitted for them.
  - During reset, in_valid is ignored.

## Configuration
- FP_COMPARE_FCLASS_EN:
  - When defined, in_op=101 performs FCLASS on in_a.
    - out_data is a one-hot 10-bit RISC-V class mask, zero-extended: bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
    - nv=0. Same latency.
  - When undefined, 101 is reserved: out_data=0, nv=1.

## Test plan
- BUS_WIDTH=32, FLT a=32'h3F800000 (1.0), b=32'h40000000 (2.0) -> out_data=1, nv=0, out_valid exactly 2 cycles after accept; swapped operands -> 0.
- FEQ a=32'h80000000 (-0), b=32'h00000000 -> out_data=1. FLE a=32'h7FC00000 (qNaN), b=1.0 -> out_data=0, nv=1. FEQ with the same qNaN -> 0, nv=0. FEQ a=32'h7F800001 (sNaN) -> 0, nv=1.
- FMIN -0/+0 -> 32'h80000000. FMAX sNaN/-1.0 (32'hBF800000) -> 32'hBF800000, nv=1. FMAX qNaN/qNaN -> 32'h7FC00000. BUS_WIDTH=64 FMIN 1.0/2.0 (64'h3FF0000000000000, 64'h4000000000000000) -> 64'h3FF0000000000000.
- Back-to-back 8 operations, tags 0..7, out_ready held low 3 cycles mid-stream:
  - in_ready deasserts once both stages are full.
  - Outputs hold stable while stalled.
  - All 8 results emerge in order with correct tags; continuous throughput of 1/cycle otherwise.
- rst asserted with both stages valid -> next cycle out_valid=0, out_data=0, in_ready=1. No stale result appears after reset release.
- With FP_COMPARE_FCLASS_EN defined: FCLASS 32'hFF800000 -> 1, 32'h00000001 -> 32, 32'h7F800001 -> 256. Undefined: same op -> 0, nv=1.

Source files
------------

// File: rtl/fp_compare_unit.sv
// Two-stage IEEE-754 compare/select (FEQ/FLT/FLE/FMIN/FMAX) with a valid/ready handshake and tag passthrough.
// Defining FP_COMPARE_FCLASS_EN adds FCLASS on in_op=101; otherwise that encoding is reserved.
module fp_compare_unit #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_nv,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int EXP_W  = (BUS_WIDTH == 32) ? 8 : 11;
  localparam int MANT_W = BUS_WIDTH - 1 - EXP_W;
  localparam logic [BUS_WIDTH-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;
`ifdef FP_COMPARE_FCLASS_EN
  localparam logic [2:0] OP_FCLASS = 3'b101;
`endif

  function automatic logic is_nan(input logic [BUS_WIDTH-1:0] x);
    return (&x[BUS_WIDTH-2 -: EXP_W]) && (|x[MANT_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [BUS_WIDTH-1:0] x);
    return is_nan(x) && !x[MANT_W-1];
  endfunction

  function automatic logic is_zero(input logic [BUS_WIDTH-1:0] x);
    return ~|x[BUS_WIDTH-2:0];
  endfunction

`ifdef FP_COMPARE_FCLASS_EN
  // One-hot class mask, bit order -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN.
  function automatic logic [9:0] fclass(input logic [BUS_WIDTH-1:0] x);
    logic neg, exp_ones, exp_zero, mant_zero;
    neg       = x[BUS_WIDTH-1];
    exp_ones  = &x[BUS_WIDTH-2 -: EXP_W];
    exp_zero  = ~|x[BUS_WIDTH-2 -: EXP_W];
    mant_zero = ~|x[MANT_W-1:0];
    if (exp_ones && !mant_zero) return x[MANT_W-1] ? 10'd512 : 10'd256;
    if (exp_ones)               return neg ? 10'd1 : 10'd128;
    if (exp_zero && mant_zero)  return neg ? 10'd8 : 10'd16;
    if (exp_zero)               return neg ? 10'd4 : 10'd32;
    return neg ? 10'd2 : 10'd64;
  endfunction
`endif

  logic                 s1_valid, s2_valid;
  logic                 s1_adv, s2_adv;
  logic [BUS_WIDTH-1:0] s1_a, s1_b;
  logic                 s1_a_nan, s1_a_snan, s1_a_zero;
  logic                 s1_b_nan, s1_b_snan, s1_b_zero;
  logic                 s1_lt, s1_eq;
  logic [2:0]           s1_op;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 in_lt;
  logic                 any_nan, any_snan, both_zero;
  logic [BUS_WIDTH-1:0] res_data;
  logic                 res_nv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Sign-magnitude total order; -0 sorts below +0 here, compares fold zeros later.
  always_comb begin
    case ({in_a[BUS_WIDTH-1], in_b[BUS_WIDTH-1]})
      2'b10:   in_lt = 1'b1;
      2'b01:   in_lt = 1'b0;
      2'b00:   in_lt = in_a[BUS_WIDTH-2:0] < in_b[BUS_WIDTH-2:0];
      default: in_lt = in_a[BUS_WIDTH-2:0] > in_b[BUS_WIDTH-2:0];
    endcase
  end

  always_comb begin
    any_nan   = s1_a_nan || s1_b_nan;
    any_snan  = s1_a_snan || s1_b_snan;
    both_zero = s1_a_zero && s1_b_zero;
    res_data  = '0;
    res_nv    = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        res_data[0] = !any_nan && (s1_eq || both_zero);
        res_nv      = any_snan;
      end
      OP_FLT: begin
        res_data[0] = !any_nan && s1_lt && !both_zero;
        res_nv      = any_nan;
      end
      OP_FLE: begin
        res_data[0] = !any_nan && (s1_lt || s1_eq || both_zero);
        res_nv      = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (s1_a_nan && s1_b_nan)             res_data = CANON_NAN;
        else if (s1_a_nan)                    res_data = s1_b;
        else if (s1_b_nan)                    res_data = s1_a;
        else if ((s1_op == OP_FMIN) == s1_lt) res_data = s1_a;
        else                                  res_data = s1_b;
      end
`ifdef FP_COMPARE_FCLASS_EN
      OP_FCLASS: res_data[9:0] = fclass(s1_a);
`endif
      default: res_nv = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_a_nan  <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_lt     <= 1'b0;
      s1_eq     <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
      out_data  <= '0;
      out_nv    <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a      <= in_a;
          s1_b      <= in_b;
          s1_a_nan  <= is_nan(in_a);
          s1_a_snan <= is_snan(in_a);
          s1_a_zero <= is_zero(in_a);
          s1_b_nan  <= is_nan(in_b);
          s1_b_snan <= is_snan(in_b);
          s1_b_zero <= is_zero(in_b);
          s1_lt     <= in_lt;
          s1_eq     <= (in_a == in_b);
          s1_op     <= in_op;
          s1_tag    <= in_tag;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res_data;
          out_nv   <= res_nv;
          out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_unit.sv
// Bench for fp_compare_unit: 32- and 64-bit instances checked every cycle against a value-level reference model.
// Honours FP_COMPARE_FCLASS_EN the same way the design does.
module tb_fp_compare_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv32, ir32, ov32, or32, onv32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, od32;
  logic [4:0]  tag32, otag32;
  logic        iv64, ir64, ov64, or64, onv64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, od64;
  logic [4:0]  tag64, otag64;

  fp_compare_unit #(.BUS_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_op(op32),
    .in_a(a32), .in_b(b32), .in_tag(tag32), .out_valid(ov32), .out_ready(or32),
    .out_data(od32), .out_nv(onv32), .out_tag(otag32));

  fp_compare_unit #(.BUS_WIDTH(64), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_op(op64),
    .in_a(a64), .in_b(b64), .in_tag(tag64), .out_valid(ov64), .out_ready(or64),
    .out_data(od64), .out_nv(onv64), .out_tag(otag64));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {nv, data}; values ordered as signed integers of their magnitude.
  function automatic logic [64:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
    int ew, mw;
    logic [63:0] mag_mask, ma, mb, ea, eb, fa, fb, emax, canon, d;
    logic sa, sb, nan_a, nan_b, snan_a, snan_b, nv, a_first;
    longint va, vb;
    ew = (w == 32) ? 8 : 11;
    mw = w - 1 - ew;
    mag_mask = (64'd1 << (w - 1)) - 64'd1;
    emax = (64'd1 << ew) - 64'd1;
    ma = a & mag_mask;  mb = b & mag_mask;
    sa = a[w-1];        sb = b[w-1];
    ea = ma >> mw;      eb = mb >> mw;
    fa = ma & ((64'd1 << mw) - 64'd1);
    fb = mb & ((64'd1 << mw) - 64'd1);
    nan_a  = (ea == emax) && (fa != 0);
    nan_b  = (eb == emax) && (fb != 0);
    snan_a = nan_a && (((fa >> (mw - 1)) & 64'd1) == 0);
    snan_b = nan_b && (((fb >> (mw - 1)) & 64'd1) == 0);
    va = sa ? -longint'(ma) : longint'(ma);
    vb = sb ? -longint'(mb) : longint'(mb);
    canon = (w == 32) ? 64'h7FC00000 : 64'h7FF8000000000000;
    d = 64'd0;
    nv = 1'b0;
    case (op)
      3'd0: begin d = {63'd0, !nan_a && !nan_b && va == vb}; nv = snan_a || snan_b; end
      3'd1: begin d = {63'd0, !nan_a && !nan_b && va <  vb}; nv = nan_a || nan_b; end
      3'd2: begin d = {63'd0, !nan_a && !nan_b && va <= vb}; nv = nan_a || nan_b; end
      3'd3, 3'd4: begin
        nv = snan_a || snan_b;
        a_first = (va < vb) || (va == vb && sa && !sb);
        if (nan_a && nan_b) d = canon;
        else if (nan_a)     d = b;
        else if (nan_b)     d = a;
        else if (op == 3'd3) d = a_first ? a : b;
        else                 d = a_first ? b : a;
      end
`ifdef FP_COMPARE_FCLASS_EN
      3'd5: begin
        if (nan_a)           d = snan_a ? 64'd256 : 64'd512;
        else if (ea == emax) d = sa ? 64'd1 : 64'd128;
        else if (ma == 0)    d = sa ? 64'd8 : 64'd16;
        else if (ea == 0)    d = sa ? 64'd4 : 64'd32;
        else                 d = sa ? 64'd2 : 64'd64;
      end
`endif
      default: nv = 1'b1;
    endcase
    return {nv, d};
  endfunction

  function automatic logic [63:0] rand_fp(input int w);
    int ew, mw;
    logic [63:0] s, e, m, emax;
    ew = (w == 32) ? 8 : 11;
    mw = w - 1 - ew;
    emax = (64'd1 << ew) - 64'd1;
    s = 64'($urandom_range(0, 1));
    m = {32'($urandom), 32'($urandom)} & ((64'd1 << mw) - 64'd1);
    case ($urandom_range(0, 6))
      0: begin e = 64'd0; m = 64'd0; end
      1: begin e = emax; m = m | (64'd1 << (mw - 1)); end
      2: begin e = emax; m = m & ~(64'd1 << (mw - 1)); if (m == 0) m = 64'd1; end
      3: begin e = emax; m = 64'd0; end
      4: begin e = 64'd0; if (m == 0) m = 64'd1; end
      5: begin e = (emax >> 1) + 64'($urandom_range(0, 2)); m = m & 64'd3; end
      default: e = 64'($urandom_range(1, int'(emax) - 1));
    endcase
    return (s << (w - 1)) | (e << mw) | m;
  endfunction

  typedef struct {
    logic [63:0] d;
    logic        nv;
    logic [4:0]  tag;
    int          acc;
  } item_t;

  item_t       sb_q [2][$];
  int          cyc = 0;
  bit          saw_backpressure = 0;
  logic        s_ov [2], s_ir [2], s_or [2], s_iv [2], s_onv [2];
  logic [63:0] s_od [2], s_ia [2], s_ib [2];
  logic [2:0]  s_op [2];
  logic [4:0]  s_otag [2], s_itag [2];

  assign s_ov[0] = ov32;  assign s_ir[0] = ir32;  assign s_or[0] = or32;  assign s_iv[0] = iv32;
  assign s_onv[0] = onv32; assign s_od[0] = {32'd0, od32}; assign s_otag[0] = otag32;
  assign s_ia[0] = {32'd0, a32}; assign s_ib[0] = {32'd0, b32}; assign s_op[0] = op32; assign s_itag[0] = tag32;
  assign s_ov[1] = ov64;  assign s_ir[1] = ir64;  assign s_or[1] = or64;  assign s_iv[1] = iv64;
  assign s_onv[1] = onv64; assign s_od[1] = od64; assign s_otag[1] = otag64;
  assign s_ia[1] = a64; assign s_ib[1] = b64; assign s_op[1] = op64; assign s_itag[1] = tag64;

  // Occupancy-based expectations: at most two in flight, head visible two cycles after acceptance.
  always @(negedge clk) begin : scoreboard
    int n, w;
    logic [64:0] r;
    item_t it;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 32 : 64;
      if (rst) begin
        sb_q[i].delete();
      end else begin
        n = sb_q[i].size();
        check($sformatf("in_ready_w%0d", w), 65'(s_ir[i]), 65'(!(n == 2 && !s_or[i])));
        check($sformatf("out_valid_w%0d", w), 65'(s_ov[i]), 65'(n > 0 && (cyc - sb_q[i][0].acc) >= 2));
        if (s_ov[i] && n > 0) begin
          check($sformatf("data_w%0d_tag%0d", w, sb_q[i][0].tag), 65'(s_od[i]), 65'(sb_q[i][0].d));
          check($sformatf("nv_w%0d_tag%0d", w, sb_q[i][0].tag), 65'(s_onv[i]), 65'(sb_q[i][0].nv));
          check($sformatf("tag_w%0d", w), 65'(s_otag[i]), 65'(sb_q[i][0].tag));
          if (s_or[i]) void'(sb_q[i].pop_front());
        end
        if (i == 0 && s_ov[i] && !s_ir[i]) saw_backpressure = 1;
        if (s_iv[i] && s_ir[i]) begin
          r = ref_model(w, s_op[i], s_ia[i], s_ib[i]);
          it.d = r[63:0];
          it.nv = r[64];
          it.tag = s_itag[i];
          it.acc = cyc;
          sb_q[i].push_back(it);
        end
      end
    end
  end

  task automatic send(input int i, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tag);
    int n;
    if (clk == 1'b0) begin
      @(posedge clk);
      #1;
    end
    if (i == 0) begin iv32 = 1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; tag32 = tag; end
    else        begin iv64 = 1; op64 = op; a64 = a;       b64 = b;       tag64 = tag; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((i == 0) ? ir32 : ir64) && n < 200);
    if (n >= 200) check("accept_timeout", 65'd0, 65'd1);
    @(posedge clk);
    #1;
    if (i == 0) iv32 = 0; else iv64 = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q[0].size() + sb_q[1].size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 65'(sb_q[0].size() + sb_q[1].size()), 65'd0);
  endtask

  task automatic rand_driver(input int i, input int count);
    int w;
    logic [63:0] a, b;
    w = (i == 0) ? 32 : 64;
    for (int k = 0; k < count; k++) begin
      a = rand_fp(w);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (64'd1 << (w - 1));
        default: b = rand_fp(w);
      endcase
      send(i, 3'($urandom_range(0, 7)), a, b, 5'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  bit rand_phase = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    iv32 = 0; op32 = 0; a32 = 0; b32 = 0; tag32 = 0; or32 = 1;
    iv64 = 0; op64 = 0; a64 = 0; b64 = 0; tag64 = 0; or64 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_out_valid", 65'(ov32), 65'd0);
    check("reset_out_data", 65'(od32), 65'd0);
    check("reset_out_nv", 65'(onv32), 65'd0);
    check("reset_out_tag", 65'(otag32), 65'd0);
    check("reset_in_ready", 65'(ir32), 65'd1);

    check("pin_flt", ref_model(32, 3'd1, 64'h3F800000, 64'h40000000), {1'b0, 64'd1});
    check("pin_flt_swap", ref_model(32, 3'd1, 64'h40000000, 64'h3F800000), {1'b0, 64'd0});
    check("pin_feq_zeros", ref_model(32, 3'd0, 64'h80000000, 64'h00000000), {1'b0, 64'd1});
    check("pin_fle_qnan", ref_model(32, 3'd2, 64'h7FC00000, 64'h3F800000), {1'b1, 64'd0});
    check("pin_feq_qnan", ref_model(32, 3'd0, 64'h7FC00000, 64'h7FC00000), {1'b0, 64'd0});
    check("pin_feq_snan", ref_model(32, 3'd0, 64'h7F800001, 64'h3F800000), {1'b1, 64'd0});
    check("pin_fmin_zeros", ref_model(32, 3'd3, 64'h80000000, 64'h00000000), {1'b0, 64'h80000000});
    check("pin_fmax_snan", ref_model(32, 3'd4, 64'h7F800001, 64'hBF800000), {1'b1, 64'hBF800000});
    check("pin_fmax_2qnan", ref_model(32, 3'd4, 64'h7FC00000, 64'h7FC00000), {1'b0, 64'h7FC00000});
    check("pin_fmin64", ref_model(64, 3'd3, 64'h3FF0000000000000, 64'h4000000000000000),
          {1'b0, 64'h3FF0000000000000});
    check("pin_reserved", ref_model(32, 3'd7, 64'h3F800000, 64'h3F800000), {1'b1, 64'd0});
`ifdef FP_COMPARE_FCLASS_EN
    check("pin_fclass_ninf", ref_model(32, 3'd5, 64'hFF800000, 64'd0), {1'b0, 64'd1});
    check("pin_fclass_psub", ref_model(32, 3'd5, 64'h00000001, 64'd0), {1'b0, 64'd32});
    check("pin_fclass_snan", ref_model(32, 3'd5, 64'h7F800001, 64'd0), {1'b0, 64'd256});
`else
    check("pin_op5_reserved", ref_model(32, 3'd5, 64'hFF800000, 64'd0), {1'b1, 64'd0});
`endif

    // Latency: accepted in one cycle, visible two cycles later.
    send(0, 3'd1, 64'h3F800000, 64'h40000000, 5'd9);
    @(negedge clk);
    check("lat_early", 65'(ov32), 65'd0);
    @(negedge clk);
    check("lat_valid", 65'(ov32), 65'd1);
    check("lat_flt_data", 65'(od32), 65'd1);
    check("lat_flt_nv", 65'(onv32), 65'd0);
    send(0, 3'd1, 64'h40000000, 64'h3F800000, 5'd10);
    @(negedge clk);
    @(negedge clk);
    check("flt_swap_data", 65'(od32), 65'd0);

    send(0, 3'd0, 64'h80000000, 64'h00000000, 5'd1);
    send(0, 3'd2, 64'h7FC00000, 64'h3F800000, 5'd2);
    send(0, 3'd0, 64'h7FC00000, 64'h7FC00000, 5'd3);
    send(0, 3'd0, 64'h7F800001, 64'h3F800000, 5'd4);
    send(0, 3'd3, 64'h80000000, 64'h00000000, 5'd5);
    send(0, 3'd4, 64'h7F800001, 64'hBF800000, 5'd6);
    send(0, 3'd4, 64'h7FC00000, 64'h7FC00000, 5'd7);
    send(0, 3'd5, 64'hFF800000, 64'd0, 5'd8);
    send(0, 3'd5, 64'h00000001, 64'd0, 5'd9);
    send(0, 3'd5, 64'h7F800001, 64'd0, 5'd10);
    send(0, 3'd7, 64'h3F800000, 64'h3F800000, 5'd11);
    send(1, 3'd3, 64'h3FF0000000000000, 64'h4000000000000000, 5'd12);
    drain();

    // Eight back-to-back operations with a three-cycle consumer stall in the middle.
    saw_backpressure = 0;
    fork
      begin
        for (int t = 0; t < 8; t++) send(0, 3'(t % 5), rand_fp(32), rand_fp(32), 5'(t));
      end
      begin
        repeat (4) @(posedge clk);
        #1 or32 = 0;
        repeat (3) @(posedge clk);
        #1 or32 = 1;
      end
    join
    drain();
    check("backpressure_seen", 65'(saw_backpressure), 65'd1);

    // Reset with both stages occupied drops everything.
    or32 = 0;
    send(0, 3'd0, 64'h3F800000, 64'h3F800000, 5'd20);
    send(0, 3'd1, 64'h3F800000, 64'h40000000, 5'd21);
    @(negedge clk);
    check("full_out_valid", 65'(ov32), 65'd1);
    check("full_in_ready", 65'(ir32), 65'd0);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_mid_out_valid", 65'(ov32), 65'd0);
    check("rst_mid_out_data", 65'(od32), 65'd0);
    check("rst_mid_in_ready", 65'(ir32), 65'd1);
    or32 = 1;
    repeat (5) @(negedge clk);

    // Randomized traffic on both widths with random consumer stalls.
    rand_phase = 1;
    fork
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          or32 = ($urandom_range(0, 3) != 0);
          or64 = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    fork
      rand_driver(0, 200);
      rand_driver(1, 200);
    join
    rand_phase = 0;
    @(posedge clk);
    #2;
    or32 = 1;
    or64 = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
